// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined minifloat multiplier with valid/ready handshake.
//
// Build option: FP_MULT_RNE_EN selects round-to-nearest-even. Without it the
// result is truncated (round toward zero).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready = out_ready | ~out_valid
//   in_a, in_b [W]       operands packed {sign, exp, mant}
//   in_mode              0: float multiply, 1: unsigned integer product (low W bits)
//   out_valid/out_ready  result handshake
//   out_res [W]          result
//   out_ovf              float result saturated to max magnitude
//   out_unf              nonzero exact product flushed to zero
//
// Stages: S1 unpack and multiply, S2 normalise and denormalise, S3 round and pack.
module fp_mult_pipe #(
    parameter  int EXP_W = 3,
    parameter  int MAN_W = 4,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int BIAS  = 2**(EXP_W-1) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic         out_ovf,
    output logic         out_unf
);
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2*MAN_W + 2;
    // Signed exponent width: wide enough for e_a+e_b-BIAS minus the largest normalising shift.
    localparam int EW   = EXP_W + 6;
    localparam int LZW  = $clog2(PW);
    localparam int MAXE = 2**EXP_W - 1;

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // S1: unpack, multiply mantissas, add exponents
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
    logic             s1_z_d, s1_s_d;
    logic [PW-1:0]    s1_p_d;
    logic [EW-1:0]    s1_e_d;
    logic [W-1:0]     s1_ip_d;
    logic             s1_v_q, s1_m_q, s1_z_q, s1_s_q;
    logic [PW-1:0]    s1_p_q;
    logic [EW-1:0]    s1_e_q;
    logic [W-1:0]     s1_ip_q;

    always_comb begin
        ea      = (in_a[W-2:MAN_W] == '0) ? EXP_W'(1) : in_a[W-2:MAN_W];
        eb      = (in_b[W-2:MAN_W] == '0) ? EXP_W'(1) : in_b[W-2:MAN_W];
        ma      = {in_a[W-2:MAN_W] != '0, in_a[MAN_W-1:0]};
        mb      = {in_b[W-2:MAN_W] != '0, in_b[MAN_W-1:0]};
        s1_z_d  = (in_a[W-2:0] == '0) | (in_b[W-2:0] == '0);
        s1_s_d  = in_a[W-1] ^ in_b[W-1];
        s1_p_d  = PW'(ma) * PW'(mb);
        s1_e_d  = EW'(ea) + EW'(eb) - EW'(BIAS);
        s1_ip_d = in_a * in_b;
    end

    // S2: move the leading one to the top bit, then denormalise if the exponent is below 1.
    // The product's hidden-bit position is bit PW-2, so a zero leading-zero count means exp+1.
    logic [LZW-1:0] lz;
    logic [PW-1:0]  m_n;
    logic [EW-1:0]  e_n, sh, shv, s2_e_d;
    logic           sub;
    logic [MW-1:0]  s2_hm_d;
    logic           s2_v_q, s2_m_q, s2_z_q, s2_s_q;
    logic [MW-1:0]  s2_hm_q;
    logic [EW-1:0]  s2_e_q;
    logic [W-1:0]   s2_ip_q;
`ifdef FP_MULT_RNE_EN
    logic [2*PW-1:0] x;
    logic            s2_g_d, s2_st_d, s2_g_q, s2_st_q;
`endif

    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) if (s1_p_q[i]) lz = LZW'(PW - 1 - i);
        m_n    = s1_p_q << lz;
        e_n    = s1_e_q + EW'(1) - EW'(lz);
        sub    = e_n[EW-1] | (e_n == '0);
        sh     = EW'(1) - e_n;
        // Shifts of PW or more leave only sticky bits, so clamp there.
        shv    = sub ? ((sh > EW'(PW)) ? EW'(PW) : sh) : '0;
        s2_e_d = sub ? '0 : e_n;
`ifdef FP_MULT_RNE_EN
        x       = {m_n, {PW{1'b0}}} >> shv;
        s2_hm_d = x[2*PW-1 -: MW];
        s2_g_d  = x[2*PW-2-MAN_W];
        s2_st_d = |x[2*PW-3-MAN_W:0];
`else
        s2_hm_d = MW'(m_n >> (PW - MW)) >> shv;
`endif
    end

    // S3: round, saturate, flush, pack
    logic          inc;
    logic [MW:0]   rnd;
    logic [EW-1:0] fe;
    logic [W-1:0]  out_res_d;
    logic          out_ovf_d, out_unf_d;
    logic          out_v_q, out_ovf_q, out_unf_q;
    logic [W-1:0]  out_res_q;

    always_comb begin
`ifdef FP_MULT_RNE_EN
        inc = s2_g_q & (s2_st_q | s2_hm_q[0]);
`else
        inc = 1'b0;
`endif
        rnd = {1'b0, s2_hm_q} + (MW+1)'(inc);
        // Carry out of a normal mantissa bumps the exponent; a subnormal that rounds
        // into the hidden bit becomes the minimum normal.
        fe  = s2_e_q + EW'(rnd[MW]) + EW'((s2_e_q == '0) & rnd[MW-1]);
        out_res_d = '0;
        out_ovf_d = 1'b0;
        out_unf_d = 1'b0;
        if (s2_m_q) begin
            out_res_d = s2_ip_q;
        end else if (!s2_z_q) begin
            if (fe > EW'(MAXE)) begin
                out_res_d = {s2_s_q, {(W-1){1'b1}}};
                out_ovf_d = 1'b1;
            end else if (fe == '0 && rnd[MAN_W-1:0] == '0) begin
                out_unf_d = 1'b1;
            end else begin
                out_res_d = {s2_s_q, fe[EXP_W-1:0], rnd[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_m_q    <= 1'b0;
            s1_z_q    <= 1'b0;
            s1_s_q    <= 1'b0;
            s1_p_q    <= '0;
            s1_e_q    <= '0;
            s1_ip_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_m_q    <= 1'b0;
            s2_z_q    <= 1'b0;
            s2_s_q    <= 1'b0;
            s2_hm_q   <= '0;
            s2_e_q    <= '0;
            s2_ip_q   <= '0;
`ifdef FP_MULT_RNE_EN
            s2_g_q    <= 1'b0;
            s2_st_q   <= 1'b0;
`endif
            out_v_q   <= 1'b0;
            out_res_q <= '0;
            out_ovf_q <= 1'b0;
            out_unf_q <= 1'b0;
        end else if (adv) begin
            s1_v_q    <= in_valid;
            s1_m_q    <= in_mode;
            s1_z_q    <= s1_z_d;
            s1_s_q    <= s1_s_d;
            s1_p_q    <= s1_p_d;
            s1_e_q    <= s1_e_d;
            s1_ip_q   <= s1_ip_d;
            s2_v_q    <= s1_v_q;
            s2_m_q    <= s1_m_q;
            s2_z_q    <= s1_z_q;
            s2_s_q    <= s1_s_q;
            s2_hm_q   <= s2_hm_d;
            s2_e_q    <= s2_e_d;
            s2_ip_q   <= s1_ip_q;
`ifdef FP_MULT_RNE_EN
            s2_g_q    <= s2_g_d;
            s2_st_q   <= s2_st_d;
`endif
            out_v_q   <= s2_v_q;
            out_res_q <= out_res_d;
            out_ovf_q <= out_ovf_d;
            out_unf_q <= out_unf_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_res   = out_res_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, 3-stage pipelined sign/exponent/mantissa multiplier with a valid/ready handshake, the next generation of the team's 8-bit minifloat multiplier. It supports arbitrary exponent and mantissa widths, subnormal operands and results, overflow saturation with status flags, and an integer bypass mode. It sits in the LSTM datapath between the operand fetch stage and the accumulator and sustains one product per cycle.

## Interface
- `EXP_W`, default 3: exponent width. Legal range 2..8.
- `MAN_W`, default 4: stored mantissa width. Legal range 2..10.
- `W`, derived as 1+EXP_W+MAN_W: operand and result width.
- `BIAS`, derived as 2^(EXP_W-1)-1: exponent bias.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: pipeline can accept operands this cycle.
- `in_a`, `in_b` input W: operands, packed as {sign, exp, mant}.
- `in_mode` input 1: 0 selects float multiply; 1 selects the unsigned integer product of the low W bits. Sampled together with the operands.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_res` output W: result.
- `out_ovf` output 1: float result saturated. Always 0 in integer mode.
- `out_unf` output 1: a nonzero exact product was flushed to zero. Always 0 in integer mode.

## Operation
- Number format:
  - Exponent 0 is subnormal, with value 0.m × 2^(1-BIAS).
  - All other exponents are normal, with value 1.m × 2^(e-BIAS).
  - There is no Inf or NaN. All-ones exponent is an ordinary normal value.
- Zero: if either operand has exp=0 and mant=0 (either sign), the float result is all zeros, with `out_ovf`=0 and `out_unf`=0.
- Sign: the result sign is sign_a XOR sign_b. Any zero result is forced to sign 0.
- S1 (unpack/multiply):
  - Insert the hidden bit: 1 for normal operands, 0 for subnormal.
  - Effective exponent is 1 for subnormal operands, otherwise the stored exponent.
  - Form the (2·MAN_W+2)-bit mantissa product and the signed exponent sum e_a+e_b-BIAS. Keep enough bits that this sum never wraps.
  - In integer mode, compute the product in_a×in_b, truncated to W bits.
- S2 (normalise):
  - Locate the leading one and shift it to the hidden-bit position. Adjust the exponent by the shift amount.
  - If the adjusted exponent is below 1, right-shift the mantissa by (1 - exp) and set exp to 0 (subnormal).
  - Collect guard and sticky bits across all right-shifts.
- S3 (round/pack):
  - Round per the Configuration section.
  - A rounding carry out of the mantissa increments the exponent. A rounding carry out of a subnormal becomes the minimum normal value.
  - If the final exponent exceeds 2^EXP_W-1, the result is {sign, all-ones exp, all-ones mant} and `out_ovf`=1.
  - If the exact product is nonzero but the rounded magnitude is 0, the result is 0 and `out_unf`=1.
- Handshake: valid/ready on both sides.
  - A transfer occurs when valid and ready are both high.
  - The pipeline advances when `out_ready`=1 or `out_valid`=0. When it cannot advance, all stages hold.
  - `in_ready` = `out_ready` OR NOT `out_valid`. Bubbles inside the pipe are not collapsed.
  - While `out_valid`=1 and `out_ready`=0, `out_res`, `out_ovf` and `out_unf` stay stable.

## Timing
- Latency: exactly 3 cycles from input transfer to `out_valid` when there is no backpressure.
- Throughput: 1 result per cycle.
- Simultaneous input and output transfers in the same cycle are legal and lose no data.
- Reset state: all stage valids are 0; `out_valid`=0; `out_res`=0; `out_ovf`=0; `out_unf`=0; `in_ready`=1 (combinational).
- Reset asserted mid-operation discards all in-flight products. No output transfer occurs for those products.
- Results are registered. No combinational path runs from `in_*` to `out_*`. `in_ready` depends combinationally only on `out_ready` and `out_valid`.

## Configuration
- `FP_MULT_RNE_EN`:
  - Defined: round to nearest, ties to even, using the guard and sticky bits.
  - Undefined: truncation, i.e. round toward zero. The guard/sticky logic is removed. Overflow saturation and underflow flushing still apply.

## Test plan
All values use EXP_W=3, MAN_W=4.
- Basic normal: 0x38 (1.5) × 0x38 → 0x42 (2.25) after 3 cycles; `out_ovf`=0, `out_unf`=0. Sign check: 0xB8 × 0x38 → 0xC2.
- Rounding: 0x33 × 0x33 → 0x37 with `FP_MULT_RNE_EN` defined, 0x36 without it.
- Subnormal and limits:
  - 0x01 × 0x30 → 0x01.
  - 0x01 × 0x01 → 0x00 with `out_unf`=1.
  - 0x7F × 0x7F → 0x7F with `out_ovf`=1.
  - 0x80 × 0x55 → 0x00.
- Integer mode: `in_mode`=1, 0x0C × 0x0B → 0x84, with both flags 0.
- Backpressure:
  - Issue 6 back-to-back pairs while holding `out_ready`=0 from cycle 4 to cycle 8.
  - Require `in_ready`=0 while the pipe is full and `out_res` stable while stalled.
  - All 6 results must appear in order with none lost or duplicated.
- Reset mid-flight: assert `rst_n`=0 with 3 products in flight → `out_valid`=0 immediately. After release, the first new pair returns exactly 3 cycles after its transfer.
